// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control slice: arbiter FSM states and
// alu_mux op-select width/codes (also used by alu_top).
package alu_ctrl_pkg;

  localparam int unsigned ALU_OP_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_e;

  localparam logic [ALU_OP_WIDTH-1:0] OP_ADD = 3'd0;
  localparam logic [ALU_OP_WIDTH-1:0] OP_SUB = 3'd1;
  localparam logic [ALU_OP_WIDTH-1:0] OP_MUL = 3'd2;
  localparam logic [ALU_OP_WIDTH-1:0] OP_AND = 3'd3;
  localparam logic [ALU_OP_WIDTH-1:0] OP_OR  = 3'd4;
  localparam logic [ALU_OP_WIDTH-1:0] OP_XOR = 3'd5;

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Two-way round-robin grant: a lone requester wins outright, a tie goes to
// the requester that was not granted last.
module rr_arbiter2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = '0;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational alu_mux between two valid/ready requesters:
// registers the winning operands, waits ALU_LATENCY cycles, returns the result.
module alu_share_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int OP_WIDTH    = ALU_OP_WIDTH,
  parameter int ALU_LATENCY = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [1:0]               req_valid_i,
  output logic [1:0]               req_ready_o,
  input  logic [1:0][WIDTH-1:0]    req_a_i,
  input  logic [1:0][WIDTH-1:0]    req_b_i,
  input  logic [1:0][OP_WIDTH-1:0] req_op_i,
  output logic [1:0]               rsp_valid_o,
  input  logic [1:0]               rsp_ready_i,
  output logic [2*WIDTH-1:0]       rsp_data_o,
  output logic [WIDTH-1:0]         alu_num1_o,
  output logic [WIDTH-1:0]         alu_num2_o,
  output logic [OP_WIDTH-1:0]      alu_op_o,
  input  logic [2*WIDTH-1:0]       alu_result_i,
  output logic                     busy_o,
  output logic [CNT_WIDTH-1:0]     ops_done_o
);

  if (ALU_LATENCY < 1) begin : g_bad_latency
    $error("alu_share_arbiter: ALU_LATENCY must be >= 1");
  end

  localparam int SET_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(ALU_LATENCY - 1);

  arb_state_e       state_q, state_d;
  logic [1:0]       grant;
  logic             g_q;
  logic             last_grant_q;
  logic [SET_W-1:0] settle_q;
  logic             accept, capture, complete;

  rr_arbiter2 u_rr (
    .valid_i      (req_valid_i),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    accept      = 1'b0;
    capture     = 1'b0;
    complete    = 1'b0;
    case (state_q)
      IDLE: begin
        // grant is only non-zero for a valid requester, so ready implies a handshake
        req_ready_o = grant;
        accept      = |grant;
        if (accept) state_d = EXEC;
      end
      EXEC: begin
        if (settle_q == '0) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_o = g_q ? 2'b10 : 2'b01;
        if (rsp_ready_i[g_q]) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      alu_num1_o   <= '0;
      alu_num2_o   <= '0;
      alu_op_o     <= '0;
      g_q          <= 1'b0;
      settle_q     <= '0;
      rsp_data_o   <= '0;
      last_grant_q <= 1'b1;
      ops_done_o   <= '0;
    end else begin
      if (accept) begin
        alu_num1_o <= req_a_i[grant[1]];
        alu_num2_o <= req_b_i[grant[1]];
        alu_op_o   <= req_op_i[grant[1]];
        g_q        <= grant[1];
        settle_q   <= SETTLE_INIT;
      end else if (state_q == EXEC && settle_q != '0) begin
        settle_q <= settle_q - SET_W'(1);
      end
      if (capture) rsp_data_o <= alu_result_i;
      if (complete) begin
        last_grant_q <= g_q;
        ops_done_o   <= ops_done_o + CNT_WIDTH'(1);
      end
    end
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with an alu_mux stub:
// result = {num_1, num_2} ^ {13'b0, op}.
module tb_alu_share_arbiter;

  logic             clk_i = 1'b0;
  logic             reset_ni;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][7:0]  req_a;
  logic [1:0][7:0]  req_b;
  logic [1:0][2:0]  req_op;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [15:0]      rsp_data;
  logic [7:0]       alu_num1;
  logic [7:0]       alu_num2;
  logic [2:0]       alu_op;
  logic [15:0]      alu_result;
  logic             busy;
  logic [3:0]       ops_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  assign alu_result = {alu_num1, alu_num2} ^ {13'b0, alu_op};

  alu_share_arbiter #(
    .WIDTH       (8),
    .OP_WIDTH    (3),
    .ALU_LATENCY (1),
    .CNT_WIDTH   (4)
  ) dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_op_i     (req_op),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .alu_num1_o   (alu_num1),
    .alu_num2_o   (alu_num2),
    .alu_op_o     (alu_op),
    .alu_result_i (alu_result),
    .busy_o       (busy),
    .ops_done_o   (ops_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    reset_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic do_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op);
    bit seen;
    req_a[idx]     = a;
    req_b[idx]     = b;
    req_op[idx]    = op;
    req_valid[idx] = 1'b1;
    rsp_ready[idx] = 1'b1;
    #1;
    chk("op_accept", 32'(req_ready[idx]), 32'h1);
    @(negedge clk_i);
    req_valid[idx] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      if (rsp_valid[idx]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("op_rsp_seen", 32'(seen), 32'h1);
    chk("op_rsp_data", 32'(rsp_data), 32'({a, b} ^ {13'b0, op}));
    @(negedge clk_i);
    rsp_ready[idx] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_ni  = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = '0;
    repeat (2) @(negedge clk_i);

    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data",  32'(rsp_data),  32'h0);
    chk("rst_alu_num1",  32'(alu_num1),  32'h0);
    chk("rst_alu_num2",  32'(alu_num2),  32'h0);
    chk("rst_alu_op",    32'(alu_op),    32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_ops_done",  32'(ops_done),  32'h0);
    reset_ni = 1'b1;
    @(negedge clk_i);

    // Single request, with operand change right after accept
    req_a[0] = 8'h12; req_b[0] = 8'h34; req_op[0] = 3'd1; req_valid = 2'b01;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    @(negedge clk_i);
    req_valid = 2'b00;
    req_a[0]  = 8'hFF;
    #1;
    chk("t1_exec_busy",  32'(busy),      32'h1);
    chk("t1_exec_valid", 32'(rsp_valid), 32'h0);
    chk("t1_exec_ready", 32'(req_ready), 32'h0);
    chk("t1_exec_num1",  32'(alu_num1),  32'h12);
    chk("t1_exec_num2",  32'(alu_num2),  32'h34);
    chk("t1_exec_op",    32'(alu_op),    32'h1);
    @(negedge clk_i);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_data",  32'(rsp_data),  32'h1235);
    chk("t1_ops_before", 32'(ops_done), 32'h0);
    rsp_ready = 2'b01;
    @(negedge clk_i);
    chk("t1_ops_after",  32'(ops_done),  32'h1);
    chk("t1_idle_busy",  32'(busy),      32'h0);
    chk("t1_idle_valid", 32'(rsp_valid), 32'h0);
    chk("t1_hold_data",  32'(rsp_data),  32'h1235);
    chk("t1_hold_num1",  32'(alu_num1),  32'h12);
    rsp_ready = 2'b00;

    // Tie after reset, with backpressure on req0's response
    apply_reset();
    req_a[0] = 8'h01; req_b[0] = 8'h02; req_op[0] = 3'd0;
    req_a[1] = 8'h03; req_b[1] = 8'h04; req_op[1] = 3'd2;
    req_valid = 2'b11;
    #1;
    chk("tie1_ready", 32'(req_ready), 32'h1);
    @(negedge clk_i);
    req_valid = 2'b10;
    #1;
    chk("tie1_exec_ready", 32'(req_ready), 32'h0);
    @(negedge clk_i);
    chk("tie1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("tie1_rsp_data",  32'(rsp_data),  32'h0102);
    rsp_ready = 2'b10;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_rsp_data",  32'(rsp_data),  32'h0102);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
    end
    rsp_ready = 2'b01;
    @(negedge clk_i);
    chk("tie1_req1_ready", 32'(req_ready), 32'h2);
    rsp_ready = 2'b10;
    @(negedge clk_i);
    req_valid = 2'b00;
    @(negedge clk_i);
    chk("req1_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("req1_rsp_data",  32'(rsp_data),  32'h0306);
    @(negedge clk_i);
    rsp_ready = 2'b00;
    chk("req1_done_busy", 32'(busy),     32'h0);
    chk("req1_ops",       32'(ops_done), 32'h2);
    req_valid = 2'b11;
    #1;
    chk("tie2_ready", 32'(req_ready), 32'h1);
    @(negedge clk_i);
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    @(negedge clk_i);
    chk("tie2_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("tie2_rsp_data",  32'(rsp_data),  32'h0102);
    @(negedge clk_i);
    rsp_ready = 2'b00;
    chk("tie2_ops", 32'(ops_done), 32'h3);

    // Reset during EXEC with last_grant = 0
    req_valid = 2'b10;
    #1;
    chk("rx_ready", 32'(req_ready), 32'h2);
    @(negedge clk_i);
    req_valid = 2'b00;
    reset_ni  = 1'b0;
    #1;
    chk("rx_req_ready", 32'(req_ready), 32'h0);
    chk("rx_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rx_rsp_data",  32'(rsp_data),  32'h0);
    chk("rx_alu_num1",  32'(alu_num1),  32'h0);
    chk("rx_alu_num2",  32'(alu_num2),  32'h0);
    chk("rx_alu_op",    32'(alu_op),    32'h0);
    chk("rx_busy",      32'(busy),      32'h0);
    chk("rx_ops_done",  32'(ops_done),  32'h0);
    @(negedge clk_i);
    reset_ni  = 1'b1;
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("rx_no_rsp",  32'(rsp_valid), 32'h0);
      chk("rx_no_busy", 32'(busy),      32'h0);
    end
    rsp_ready = 2'b00;
    req_valid = 2'b11;
    #1;
    chk("rx_tie_ready", 32'(req_ready), 32'h1);
    req_valid = 2'b00;
    @(negedge clk_i);
    chk("drop_noop_busy", 32'(busy), 32'h0);

    // Counter wrap at CNT_WIDTH = 4
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      do_op(0, 8'(i * 7), 8'(8'hA5 ^ i), 3'(i));
      if (i == 15) chk("wrap_16_ops", 32'(ops_done), 32'h0);
    end
    chk("wrap_17_ops", 32'(ops_done), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
